tc_job_sequencer: RTL
=====================

// Module: tc_job_sequencer
// PURPOSE
//  Top-level job controller for one tensor-core GEMM tile (D = A*B + C).
//  Steps through the state_t sequence: READ_C, LOAD_A, LOAD_B, SYSTOLIC, optional ACCUMULATE, WAIT_WRITE, WRITE_BACK, FINISH.
//  Issues one AXI_out_t-style request per matrix and times the systolic array phases.
//  Sits between the host/config block, the AXI master and the systolic array.
// PARAMETERS
//  BEAT_BITS        256  AXI data beat width in bits
//  BEATS_PER_BURST  16   max beats per burst; burst_size = min(beats, BEATS_PER_BURST)
//  ACC_CYCLES       4    ACCUMULATE dwell for INT8/INT4, in cycles (>=1)
// PORTS
//  clk             in   1    single clock
//  rst_n           in   1    synchronous reset, active-low
//  start           in   1    job start pulse; sampled only in IDLE
//  cfg             in   4    compute_type_t {shape_t, type_t}
//  base            in   128  baseaddr_t {A,B,C,D}_BASE
//  timing          in   96   SYSTOLIC_pkg_t {systolic,waitwrite,writeback}_time
//  axi_out         out  82   AXI_out_t request bundle
//  axi_req_ready   in   1    AXI master accepts request when request_valid & ready
//  axi_finish      in   1    AXI_in_t.finish: current transfer complete
//  state           out  4    current state_t
//  busy            out  1    state != IDLE
//  done            out  1    1-cycle pulse in FINISH
//  cfg_err         out  1    1-cycle pulse: start with shape == 2'b11
// BEHAVIOUR
//  Reset (rst_n==0 at posedge):
//   - state=IDLE; all axi_out fields 0; done=0; cfg_err=0; counters cleared.
//   - Applies mid-job too: any outstanding request is dropped, no done.
//  IDLE:
//   - start & shape!=3: latch cfg, base and timing; next READ_C.
//   - start & shape==3: cfg_err=1 for one cycle; stay in IDLE.
//  Memory states:
//   - READ_C: sel=001, BASE=C_BASE.  LOAD_A: sel=100, BASE=A_BASE.  LOAD_B: sel=010, BASE=B_BASE.
//   - WRITE_BACK: sel=000, BASE=D_BASE, issend=1.
//   - request_valid rises the cycle after state entry and holds until valid & axi_req_ready.
//   - BASE, sel, bits and burst fields are stable while valid is high.
//   - After the handshake, wait for axi_finish, then advance.
//   - axi_finish before the handshake is ignored.
//   - axi_finish in the handshake cycle counts as completion.
//  bits (element count * width):
//   - elements: A = M*16; B = 16*N; C and D = M*N = 256.
//   - shape gives (M,N): 0=(32,8), 1=(16,16), 2=(8,32).
//   - width for A/B: FP32=32, FP16=16, INT8=8, INT4=4. C/D are always 32-bit (FP32 or INT32 accumulator).
//  Burst fields:
//   - beats = bits / BEAT_BITS.
//   - burst_size = min(beats, BEATS_PER_BURST).
//   - burst_num = ceil(beats / burst_size).
//  Timed states (32-bit down-counter loaded on entry):
//   - SYSTOLIC dwells systolic_time cycles.
//   - WAIT_WRITE dwells waitwrite_time cycles.
//   - A time of 0 is treated as 1 cycle.
//  After SYSTOLIC:
//   - INT8/INT4: ACCUMULATE for ACC_CYCLES cycles, then WAIT_WRITE.
//   - FP32/FP16: straight to WAIT_WRITE.
//  WRITE_BACK:
//   - After axi_finish, hold at least writeback_time cycles counted from entry, then FINISH.
//  FINISH:
//   - done=1 for one cycle, then IDLE.
//   - start in the FINISH cycle is ignored; the next job may start the cycle after.
//  Other rules:
//   - start while busy is ignored, with no side effects.
//   - Latched cfg, base and timing are unaffected by input changes mid-job.
// TESTING
//  1. FP16, M16K16N16, ready=1, finish 3 cycles after each handshake:
//     -> bits C=8192, A=4096, B=4096, D=8192.
//     -> C/D burst_size=16, burst_num=2; done once; no ACCUMULATE visited.
//  2. INT4, M8K16N32:
//     -> A bits=512, beats=2, burst_size=2, burst_num=1.
//     -> ACCUMULATE lasts exactly ACC_CYCLES cycles.
//  3. FP32, M32K16N8, ready held 0 for 5 cycles in LOAD_A:
//     -> request_valid=1 and BASE=A_BASE stable for all 5 cycles.
//     -> A bits=16384, burst_num=4.
//  4. start with shape=3 -> cfg_err pulse, state stays IDLE.
//     Then a start during SYSTOLIC -> ignored; the job completes unchanged.
//  5. systolic_time=0 and waitwrite_time=7:
//     -> SYSTOLIC lasts 1 cycle, WAIT_WRITE lasts 7 cycles.
//     Check the state trace cycle by cycle.
//  6. rst_n=0 during WRITE_BACK with request_valid high:
//     -> next cycle IDLE, axi_out=0, no done; a fresh job then runs cleanly.

Source files
------------

// File: rtl/tc_axi_if.sv
// Request/handshake bundle between the tensor-core job sequencer and the AXI master.
// axi_out layout (MSB..LSB): request_valid, issend, sel[2:0], base[31:0], bits[31:0], burst_size[7:0], burst_num[4:0].
interface tc_axi_if;
    logic [81:0] axi_out;
    logic        axi_req_ready;
    logic        axi_finish;

    modport master (output axi_out, input axi_req_ready, input axi_finish);
    modport slave  (input axi_out, output axi_req_ready, output axi_finish);
endinterface

// File: rtl/tc_job_sequencer.sv
// Job controller for one tensor-core GEMM tile: reads C, loads A and B, times the
// systolic/accumulate phases, then writes D back through a single AXI request per matrix.
module tc_job_sequencer #(
    parameter int unsigned BEAT_BITS       = 256,
    parameter int unsigned BEATS_PER_BURST = 16,
    parameter int unsigned ACC_CYCLES      = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [3:0]      cfg,
    input  logic [127:0]    base,
    input  logic [95:0]     timing,
    tc_axi_if.master        axi,
    output logic [3:0]      state,
    output logic            busy,
    output logic            done,
    output logic            cfg_err
);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        READ_C     = 4'd1,
        LOAD_A     = 4'd2,
        LOAD_B     = 4'd3,
        SYSTOLIC   = 4'd4,
        ACCUMULATE = 4'd5,
        WAIT_WRITE = 4'd6,
        WRITE_BACK = 4'd7,
        FINISH     = 4'd8
    } state_t;

    typedef enum logic [1:0] {T_FP32 = 2'd0, T_FP16 = 2'd1, T_INT8 = 2'd2, T_INT4 = 2'd3} type_t;

    typedef struct packed {
        logic        request_valid;
        logic        issend;
        logic [2:0]  sel;
        logic [31:0] base;
        logic [31:0] bits;
        logic [7:0]  burst_size;
        logic [4:0]  burst_num;
    } axi_out_t;

    localparam logic [31:0] CD_BITS = 32'd256 * 32'd32;

    state_t      state_q, state_d;
    logic [3:0]  cfg_q, cfg_d;
    logic [127:0] base_q, base_d;
    logic [95:0] timing_q, timing_d;
    logic [31:0] cnt_q, cnt_d;
    logic        hs_q, hs_d;
    logic        fin_q, fin_d;
    axi_out_t    axi_q, axi_d;
    logic        done_q, done_d;
    logic        cfg_err_q, cfg_err_d;

    axi_out_t    req;
    logic [31:0] m_dim, n_dim, width, beats;
    logic        is_mem, xfer_cplt, valid_d;
    type_t       type_q;

    assign type_q = type_t'(cfg_q[1:0]);

    function automatic logic [31:0] at_least_one(input logic [31:0] t);
        return (t == 32'd0) ? 32'd1 : t;
    endfunction

    function automatic logic [31:0] load_value(input state_t s, input logic [95:0] t);
        case (s)
            SYSTOLIC:   return at_least_one(t[95:64]);
            ACCUMULATE: return 32'(ACC_CYCLES);
            WAIT_WRITE: return at_least_one(t[63:32]);
            WRITE_BACK: return at_least_one(t[31:0]);
            default:    return 32'd0;
        endcase
    endfunction

    // Request fields depend only on the current state and latched job, so they stay stable while valid is high.
    always_comb begin
        req               = '0;
        req.request_valid = 1'b1;
        m_dim             = 32'd8;
        n_dim             = 32'd32;
        width             = 32'd32;
        beats             = 32'd0;
        case (cfg_q[3:2])
            2'd0:    begin m_dim = 32'd32; n_dim = 32'd8;  end
            2'd1:    begin m_dim = 32'd16; n_dim = 32'd16; end
            default: begin m_dim = 32'd8;  n_dim = 32'd32; end
        endcase
        case (type_q)
            T_FP32: width = 32'd32;
            T_FP16: width = 32'd16;
            T_INT8: width = 32'd8;
            T_INT4: width = 32'd4;
        endcase
        case (state_q)
            READ_C:     begin req.sel = 3'b001; req.base = base_q[63:32];  req.bits = CD_BITS; end
            LOAD_A:     begin req.sel = 3'b100; req.base = base_q[127:96]; req.bits = m_dim * 32'd16 * width; end
            LOAD_B:     begin req.sel = 3'b010; req.base = base_q[95:64];  req.bits = 32'd16 * n_dim * width; end
            WRITE_BACK: begin req.sel = 3'b000; req.base = base_q[31:0];   req.bits = CD_BITS; req.issend = 1'b1; end
            default:    ;
        endcase
        beats = req.bits / BEAT_BITS;
        if (beats > BEATS_PER_BURST) begin
            req.burst_size = 8'(BEATS_PER_BURST);
            req.burst_num  = 5'((beats + BEATS_PER_BURST - 32'd1) / BEATS_PER_BURST);
        end else begin
            req.burst_size = 8'(beats);
            req.burst_num  = 5'd1;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default here first, so no path through the case leaves a latch behind.
        state_d   = state_q;
        cfg_d     = cfg_q;
        base_d    = base_q;
        timing_d  = timing_q;
        cnt_d     = cnt_q;
        hs_d      = hs_q;
        fin_d     = fin_q;
        cfg_err_d = 1'b0;
        xfer_cplt = 1'b0;
        is_mem    = state_q inside {READ_C, LOAD_A, LOAD_B, WRITE_BACK};

        // A finish only counts once the request has been accepted, including in the accepting cycle.
        if (is_mem) begin
            if (!hs_q) begin
                if (axi_q.request_valid && axi.axi_req_ready) begin
                    hs_d      = 1'b1;
                    xfer_cplt = axi.axi_finish;
                end
            end else begin
                xfer_cplt = axi.axi_finish;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg[3:2] == 2'b11) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cfg_d    = cfg;
                        base_d   = base;
                        timing_d = timing;
                        state_d  = READ_C;
                    end
                end
            end
            READ_C: if (xfer_cplt) state_d = LOAD_A;
            LOAD_A: if (xfer_cplt) state_d = LOAD_B;
            LOAD_B: if (xfer_cplt) state_d = SYSTOLIC;
            SYSTOLIC: begin
                if (cnt_q <= 32'd1) begin
                    state_d = (type_q == T_INT8 || type_q == T_INT4) ? ACCUMULATE : WAIT_WRITE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ACCUMULATE: if (cnt_q <= 32'd1) state_d = WAIT_WRITE; else cnt_d = cnt_q - 32'd1;
            WAIT_WRITE: if (cnt_q <= 32'd1) state_d = WRITE_BACK; else cnt_d = cnt_q - 32'd1;
            WRITE_BACK: begin
                if (cnt_q > 32'd1) cnt_d = cnt_q - 32'd1;
                if (xfer_cplt) fin_d = 1'b1;
                if ((xfer_cplt || fin_q) && cnt_q <= 32'd1) state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = load_value(state_d, timing_d);
            hs_d  = 1'b0;
            fin_d = 1'b0;
        end

        valid_d = is_mem && !hs_d && (state_d == state_q);
        axi_d   = valid_d ? req : '0;
        done_d  = (state_d == FINISH);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only, so every flop samples the pre-edge value of every other flop.
        if (!rst_n) begin
            state_q   <= IDLE;
            cfg_q     <= '0;
            base_q    <= '0;
            timing_q  <= '0;
            cnt_q     <= '0;
            hs_q      <= 1'b0;
            fin_q     <= 1'b0;
            axi_q     <= '0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            base_q    <= base_d;
            timing_q  <= timing_d;
            cnt_q     <= cnt_d;
            hs_q      <= hs_d;
            fin_q     <= fin_d;
            axi_q     <= axi_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign axi.axi_out = axi_q;
    assign state       = state_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;

endmodule
